// File: rtl/ysyx_22050710_mem_pkg.sv
// Shared types and constants for the SRAM arbiter slice: id width helper,
// response pipeline entry and default bus widths.
package ysyx_22050710_mem_pkg;

  localparam int DEF_AW   = 32;
  localparam int DEF_DW   = 64;
  // Wide enough for the largest supported channel count (8).
  localparam int MAX_ID_W = 3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic                rd;
    logic [MAX_ID_W-1:0] id;
  } pipe_entry_t;

endpackage

// File: rtl/ysyx_22050710_rr_arbiter.sv
// One-hot request arbiter with a round-robin pointer; defining
// YSYX_22050710_SRAM_ARB_FIXED_PRIO_EN switches it to fixed priority (channel 0 highest).
module ysyx_22050710_rr_arbiter
  import ysyx_22050710_mem_pkg::*;
#(
  parameter int NCH = 2,
  localparam int IW = id_w(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  grant_id
);

  localparam logic [NCH-1:0] LSB = NCH'(1);

  logic [NCH-1:0] pick;

`ifdef YSYX_22050710_SRAM_ARB_FIXED_PRIO_EN
  assign pick = req;
`else
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  ptr_nxt;
  logic [NCH-1:0] hi_mask;
  logic [NCH-1:0] masked;

  // Channels at or above the pointer get first chance; otherwise wrap to the bottom.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
  end

  assign masked = req & hi_mask;
  assign pick   = (|masked) ? masked : req;

  always_comb begin
    ptr_nxt = ptr;
    if (|grant) begin
      ptr_nxt = (grant_id == IW'(NCH - 1)) ? '0 : grant_id + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end
`endif

  // Isolate the lowest set bit of the candidate vector.
  assign grant = pick & (~pick + LSB);

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) grant_id = IW'(i);
    end
  end

endmodule

// File: rtl/ysyx_22050710_sram_arb.sv
// Multi-channel SRAM arbiter with fixed-latency in-order responses.
// Optional build macro: YSYX_22050710_SRAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module ysyx_22050710_sram_arb
  import ysyx_22050710_mem_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1,
  localparam int SW    = DW / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_req_valid,
  output logic [NCH-1:0]    o_req_ready,
  input  logic [NCH*SW-1:0] i_req_wen,
  input  logic [NCH*AW-1:0] i_req_addr,
  input  logic [NCH*DW-1:0] i_req_wdata,
  output logic [NCH-1:0]    o_rsp_valid,
  output logic [DW-1:0]     o_rsp_rdata,
  output logic              o_mem_en,
  output logic [SW-1:0]     o_mem_wen,
  output logic [AW-1:0]     o_mem_addr,
  output logic [DW-1:0]     o_mem_wdata,
  input  logic [DW-1:0]     i_mem_rdata
);

  localparam int IW = id_w(NCH);

  // Handshake: a request transfers in the cycle where i_req_valid[c] and
  // o_req_ready[c] are both high; ready is never raised for an idle channel,
  // and o_rsp_valid cannot be back-pressured.
  logic [NCH-1:0] req_gated;
  logic [NCH-1:0] grant;
  logic [IW-1:0]  grant_id;

  assign req_gated = i_rst ? '0 : i_req_valid;

  ysyx_22050710_rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .clk      (i_clk),
    .rst      (i_rst),
    .req      (req_gated),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign o_req_ready = grant;

  always_comb begin
    o_mem_en    = |grant;
    o_mem_wen   = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant[c]) begin
        o_mem_wen   = i_req_wen[c*SW +: SW];
        o_mem_addr  = i_req_addr[c*AW +: AW];
        o_mem_wdata = i_req_wdata[c*DW +: DW];
      end
    end
  end

  // Response tracking: one entry per cycle, aligned with the SRAM latency.
  pipe_entry_t pipe_in;
  pipe_entry_t pipe_q [RD_LAT];
  pipe_entry_t head;

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = |grant;
    pipe_in.rd    = ~|o_mem_wen;
    pipe_in.id    = MAX_ID_W'(grant_id);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_in;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign head = pipe_q[RD_LAT-1];

  // Outputs are forced quiet during reset even though the pipeline clears one edge later.
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_rdata = '0;
    if (!i_rst && head.valid) begin
      for (int c = 0; c < NCH; c++) begin
        if (head.id == MAX_ID_W'(c)) o_rsp_valid[c] = 1'b1;
      end
      if (head.rd) o_rsp_rdata = i_mem_rdata;
    end
  end

endmodule
